cc_reg: RTL and testbench

//   Producer side of the condition-code interface: the Y86-64 execute-stage ALU plus the

---
 rtl/cc_reg.sv | 88 ++++++++
 tb/tb_cc_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cc_reg.sv
// Y86-64 execute-stage ALU with the architectural condition-code register.
// valE/alu_err are combinational; cur_cc/cc_upd are registered and reset asynchronously.
module cc_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alufun,
  input  logic              set_cc,
  input  logic              stall,
  input  logic              exc_pending,
  output logic [DATA_W-1:0] valE,
  output logic              alu_err,
  output logic [2:0]        cur_cc,
  output logic              cc_upd
);

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [2:0] CC_RESET = 3'b100;

  // Signed overflow from operand/result sign bits; SUB is B minus A, so B is the minuend.
  function automatic logic calc_of(input logic [3:0] fun, input logic sa, input logic sb,
                                   input logic st);
    logic of_v;
    case (fun)
      ALU_ADD: of_v = (sa == sb) && (st != sa);
      ALU_SUB: of_v = (sa != sb) && (st != sb);
      default: of_v = 1'b0;
    endcase
    return of_v;
  endfunction

  logic [DATA_W-1:0] val_s;
  logic              err_s;
  logic [2:0]        next_cc_s;
  logic              we_s;
  logic [2:0]        cc_r;
  logic              upd_r;

  // ALU datapath and illegal-function detection.
  always_comb begin
    val_s = {DATA_W{1'b0}};
    err_s = 1'b0;
    case (alufun)
      ALU_ADD: val_s = alu_b + alu_a;
      ALU_SUB: val_s = alu_b - alu_a;
      ALU_AND: val_s = alu_b & alu_a;
      ALU_XOR: val_s = alu_b ^ alu_a;
      default: begin
        val_s = {DATA_W{1'b0}};
        err_s = 1'b1;
      end
    endcase
  end

  // Candidate flags {ZF,SF,OF} and the CC write enable.
  always_comb begin
    next_cc_s = {(val_s == {DATA_W{1'b0}}), val_s[DATA_W-1],
                 calc_of(alufun, alu_a[DATA_W-1], alu_b[DATA_W-1], val_s[DATA_W-1])};
    we_s = set_cc & ~stall & ~exc_pending & ~err_s;
  end

  // CC register: reset flags say "zero result", hold whenever the write is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_r  <= CC_RESET;
      upd_r <= 1'b0;
    end else if (we_s) begin
      cc_r  <= next_cc_s;
      upd_r <= 1'b1;
    end else begin
      cc_r  <= cc_r;
      upd_r <= 1'b0;
    end
  end

  assign valE    = val_s;
  assign alu_err = err_s;
  assign cur_cc  = cc_r;
  assign cc_upd  = upd_r;

endmodule

// File: tb/tb_cc_reg.sv
// Directed and randomized checks of cc_reg against hand-computed values and a
// wide-arithmetic reference model of the ALU and flags.
module tb_cc_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alufun;
  logic        set_cc, stall, exc_pending;
  logic [63:0] valE;
  logic        alu_err;
  logic [2:0]  cur_cc;
  logic        cc_upd;

  int n_vec = 0;
  int n_miss = 0;

  cc_reg #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .alu_a(alu_a), .alu_b(alu_b), .alufun(alufun),
    .set_cc(set_cc), .stall(stall), .exc_pending(exc_pending),
    .valE(valE), .alu_err(alu_err), .cur_cc(cur_cc), .cc_upd(cc_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one instruction at the falling edge.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] f,
                       input logic s, input logic st, input logic ex);
    @(negedge clk);
    alu_a = a; alu_b = b; alufun = f; set_cc = s; stall = st; exc_pending = ex;
    #1;
  endtask

  task automatic past_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference: {err, ZF, SF, OF, val} using 65-bit signed arithmetic.
  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] f);
    logic [64:0] w;
    logic [63:0] v;
    logic of, err;
    w = 65'd0; v = 64'd0; of = 1'b0; err = 1'b0;
    case (f)
      4'h0: begin w = {b[63], b} + {a[63], a}; v = w[63:0]; of = w[64] ^ w[63]; end
      4'h1: begin w = {b[63], b} - {a[63], a}; v = w[63:0]; of = w[64] ^ w[63]; end
      4'h2: v = a & b;
      4'h3: v = a ^ b;
      default: err = 1'b1;
    endcase
    return {err, (v == 64'd0), v[63], of, v};
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] c;
    case ($urandom_range(0, 7))
      0: c = 64'd0;
      1: c = 64'd1;
      2: c = 64'h7FFF_FFFF_FFFF_FFFF;
      3: c = 64'h8000_0000_0000_0000;
      4: c = 64'hFFFF_FFFF_FFFF_FFFF;
      default: c = {$urandom(), $urandom()};
    endcase
    return c;
  endfunction

  initial begin
    logic [67:0] r;
    logic [2:0]  exp_cc;
    logic        exp_upd;
    logic        we;
    logic [3:0]  f;

    rst = 1'b1; alu_a = 64'd0; alu_b = 64'd0; alufun = 4'h0;
    set_cc = 1'b0; stall = 1'b0; exc_pending = 1'b0;
    #12;
    chk("reset_cc", {61'd0, cur_cc}, 64'd4);
    chk("reset_upd", {63'd0, cc_upd}, 64'd0);
    rst = 1'b0;

    // ADD overflow into the sign bit
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("add_val", valE, 64'h8000_0000_0000_0000);
    chk("add_err", {63'd0, alu_err}, 64'd0);
    chk("add_hold_before_edge", {61'd0, cur_cc}, 64'd4);
    past_edge();
    chk("add_cc", {61'd0, cur_cc}, 64'd3);
    chk("add_upd", {63'd0, cc_upd}, 64'd1);

    // Asynchronous reset between edges, then idle hold
    drive(64'd0, 64'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    #2; rst = 1'b1; #1;
    chk("async_rst_cc", {61'd0, cur_cc}, 64'd4);
    chk("async_rst_upd", {63'd0, cc_upd}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      past_edge();
      chk("idle_cc", {61'd0, cur_cc}, 64'd4);
      chk("idle_upd", {63'd0, cc_upd}, 64'd0);
    end

    // SUB giving zero, then SUB overflowing out of the negative range
    drive(64'd5, 64'd5, 4'h1, 1'b1, 1'b0, 1'b0);
    chk("sub0_val", valE, 64'd0);
    past_edge();
    chk("sub0_cc", {61'd0, cur_cc}, 64'd4);
    chk("sub0_upd", {63'd0, cc_upd}, 64'd1);
    drive(64'd1, 64'h8000_0000_0000_0000, 4'h1, 1'b1, 1'b0, 1'b0);
    chk("subof_val", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    past_edge();
    chk("subof_cc", {61'd0, cur_cc}, 64'd1);

    // Establish SF-only flags, then try writes under stall and exc_pending
    drive(64'd0, 64'h8000_0000_0000_0000, 4'h0, 1'b1, 1'b0, 1'b0);
    past_edge();
    chk("sf_cc", {61'd0, cur_cc}, 64'd2);
    drive(64'hFF, 64'hFF, 4'h3, 1'b1, 1'b1, 1'b0);
    chk("xor_val", valE, 64'd0);
    past_edge();
    chk("stall_cc", {61'd0, cur_cc}, 64'd2);
    chk("stall_upd", {63'd0, cc_upd}, 64'd0);
    drive(64'hFF, 64'hFF, 4'h3, 1'b1, 1'b0, 1'b1);
    past_edge();
    chk("exc_cc", {61'd0, cur_cc}, 64'd2);
    chk("exc_upd", {63'd0, cc_upd}, 64'd0);
    drive(64'hFF, 64'hFF, 4'h3, 1'b1, 1'b1, 1'b1);
    past_edge();
    chk("both_cc", {61'd0, cur_cc}, 64'd2);

    // Illegal function code
    drive(64'h1234, 64'h5678, 4'h7, 1'b1, 1'b0, 1'b0);
    chk("ill_val", valE, 64'd0);
    chk("ill_err", {63'd0, alu_err}, 64'd1);
    past_edge();
    chk("ill_cc", {61'd0, cur_cc}, 64'd2);
    chk("ill_upd", {63'd0, cc_upd}, 64'd0);

    // AND result, legal write after the hold cases
    drive(64'hF0F0, 64'h0FF0, 4'h2, 1'b1, 1'b0, 1'b0);
    chk("and_val", valE, 64'h00F0);
    past_edge();
    chk("and_cc", {61'd0, cur_cc}, 64'd0);
    chk("and_upd", {63'd0, cc_upd}, 64'd1);

    // Randomized run against the reference model, with a reset mid-sequence
    exp_cc = 3'b000; exp_upd = 1'b1;
    for (int i = 0; i < 60; i++) begin
      f = 4'($urandom_range(0, 4));
      if (f == 4'h4) f = 4'($urandom_range(4, 15));
      drive(pick(), pick(), f, ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0));
      r = ref_alu(alu_a, alu_b, alufun);
      chk("rnd_val", valE, r[63:0]);
      chk("rnd_err", {63'd0, alu_err}, {63'd0, r[67]});
      if (i == 30) begin
        #2; rst = 1'b1; #1;
        chk("rnd_rst_cc", {61'd0, cur_cc}, 64'd4);
        chk("rnd_rst_upd", {63'd0, cc_upd}, 64'd0);
        rst = 1'b0;
        exp_cc = 3'b100; exp_upd = 1'b0;
      end
      we = set_cc && !stall && !exc_pending && !r[67];
      past_edge();
      if (we) begin
        exp_cc = r[66:64];
        exp_upd = 1'b1;
      end else begin
        exp_upd = 1'b0;
      end
      chk("rnd_cc", {61'd0, cur_cc}, {61'd0, exp_cc});
      chk("rnd_upd", {63'd0, cc_upd}, {63'd0, exp_upd});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
